// File: rtl/lamp_sequence_monitor.sv
// Purpose : checks a one-hot traffic-lamp stream for legal colours, R->G->Y->R order and dwell bounds; counts lamp cycles.
// Latency : a violation on `light` before edge N shows on fault/fault_code right after edge N; all outputs registered.
// Backpressure: none, because this is a passive observer that samples `light` every clock and never stalls.
//
// Ports:
//   clock        rising-edge clock, shared with the lamp controller
//   reset_n      asynchronous active-low reset
//   light        3-bit one-hot colour (100=RED, 010=GREEN, 001=YELLOW)
//   clear_fault  synchronous request to leave FAULT (ignored elsewhere)
//   running      high while in RUN
//   fault        sticky fault flag (high while in FAULT)
//   fault_code   0 none, 1 illegal, 2 sequence, 3 dwell short, 4 dwell long
//   dwell        sampling edges the current colour has been held
//   cycle_count  completed YELLOW->RED transitions, saturating
module lamp_sequence_monitor #(
   parameter int CNT_W     = 8,
   parameter int MIN_DWELL = 1,
   parameter int MAX_DWELL = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [2:0]       light,
   input  logic             clear_fault,
   output logic             running,
   output logic             fault,
   output logic [2:0]       fault_code,
   output logic [CNT_W-1:0] dwell,
   output logic [CNT_W-1:0] cycle_count
);

   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] GREEN  = 3'b010;
   localparam logic [2:0] YELLOW = 3'b001;

   localparam logic [2:0] CODE_NONE  = 3'd0;
   localparam logic [2:0] CODE_ILL   = 3'd1;
   localparam logic [2:0] CODE_SEQ   = 3'd2;
   localparam logic [2:0] CODE_SHORT = 3'd3;
   localparam logic [2:0] CODE_LONG  = 3'd4;

   localparam logic [CNT_W-1:0] MIN_D   = CNT_W'(MIN_DWELL);
   localparam logic [CNT_W-1:0] MAX_D   = CNT_W'(MAX_DWELL);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       light_q, light_d;
   logic [2:0]       fault_code_q, fault_code_d;
   logic [CNT_W-1:0] dwell_q, dwell_d;
   logic [CNT_W-1:0] cycle_q, cycle_d;

   logic       is_onehot;
   logic       changed;
   logic [2:0] succ;

   // Expected next colour after the one held in light_q. While in RUN,
   // light_q is always a legal colour, since an illegal sample faults first.
   always_comb begin
      succ = 3'b000;
      case (light_q)
         RED:     succ = GREEN;
         GREEN:   succ = YELLOW;
         YELLOW:  succ = RED;
         default: succ = 3'b000;
      endcase
   end

   assign is_onehot = (light == RED) || (light == GREEN) || (light == YELLOW);
   assign changed   = (light != light_q);

   always_comb begin
      state_d      = state_q;
      light_d      = light;
      fault_code_d = fault_code_q;
      dwell_d      = dwell_q;
      cycle_d      = cycle_q;

      case (state_q)
         ST_IDLE: begin
            if (light == RED) begin
               state_d = ST_RUN;
               dwell_d = CNT_ONE;
            end
         end

         ST_RUN: begin
            // Checks in priority order. dwell is frozen on the faulting edge.
            if (!is_onehot) begin
               state_d      = ST_FAULT;
               fault_code_d = CODE_ILL;
            end else if (changed && (light != succ)) begin
               state_d      = ST_FAULT;
               fault_code_d = CODE_SEQ;
            end else if (changed && (dwell_q < MIN_D)) begin
               state_d      = ST_FAULT;
               fault_code_d = CODE_SHORT;
            end else if (!changed && (dwell_q == MAX_D)) begin
               state_d      = ST_FAULT;
               fault_code_d = CODE_LONG;
            end else if (!changed) begin
               dwell_d = dwell_q + CNT_ONE;
            end else begin
               dwell_d = CNT_ONE;
               if ((light_q == YELLOW) && (cycle_q != {CNT_W{1'b1}})) begin
                  cycle_d = cycle_q + CNT_ONE;
               end
            end
         end

         ST_FAULT: begin
            if (clear_fault) begin
               state_d      = ST_IDLE;
               fault_code_d = CODE_NONE;
               dwell_d      = '0;
            end
         end

         default: begin
            state_d      = ST_IDLE;
            fault_code_d = CODE_NONE;
            dwell_d      = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         light_q      <= 3'b000;
         fault_code_q <= CODE_NONE;
         dwell_q      <= '0;
         cycle_q      <= '0;
      end else begin
         state_q      <= state_d;
         light_q      <= light_d;
         fault_code_q <= fault_code_d;
         dwell_q      <= dwell_d;
         cycle_q      <= cycle_d;
      end
   end

   assign running     = (state_q == ST_RUN);
   assign fault       = (state_q == ST_FAULT);
   assign fault_code  = fault_code_q;
   assign dwell       = dwell_q;
   assign cycle_count = cycle_q;

endmodule

// File: tb/tb_lamp_sequence_monitor.sv
// Purpose : directed bench for lamp_sequence_monitor (default params and MIN_DWELL=3 instance).
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; inputs are driven between edges.
module tb_lamp_sequence_monitor;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] G = 3'b010;
   localparam logic [2:0] Y = 3'b001;

   logic       clock;
   logic       reset_n;
   logic [2:0] light;
   logic       clear_fault;

   logic       running_a, fault_a;
   logic [2:0] code_a;
   logic [7:0] dwell_a, cyc_a;

   logic       running_b, fault_b;
   logic [2:0] code_b;
   logic [7:0] dwell_b, cyc_b;

   int checks = 0;
   int errors = 0;

   lamp_sequence_monitor #(.CNT_W(8), .MIN_DWELL(1), .MAX_DWELL(16)) dut_a (
      .clock       (clock),
      .reset_n     (reset_n),
      .light       (light),
      .clear_fault (clear_fault),
      .running     (running_a),
      .fault       (fault_a),
      .fault_code  (code_a),
      .dwell       (dwell_a),
      .cycle_count (cyc_a)
   );

   lamp_sequence_monitor #(.CNT_W(8), .MIN_DWELL(3), .MAX_DWELL(16)) dut_b (
      .clock       (clock),
      .reset_n     (reset_n),
      .light       (light),
      .clear_fault (clear_fault),
      .running     (running_b),
      .fault       (fault_b),
      .fault_code  (code_b),
      .dwell       (dwell_b),
      .cycle_count (cyc_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Checks all five outputs of the default-parameter instance.
   task automatic chk_a(input string tag, input logic run, input logic flt,
                        input logic [2:0] code, input logic [7:0] dw, input logic [7:0] cyc);
      chk({tag, ".running"},     {31'd0, running_a}, {31'd0, run});
      chk({tag, ".fault"},       {31'd0, fault_a},   {31'd0, flt});
      chk({tag, ".fault_code"},  {29'd0, code_a},    {29'd0, code});
      chk({tag, ".dwell"},       {24'd0, dwell_a},   {24'd0, dw});
      chk({tag, ".cycle_count"}, {24'd0, cyc_a},     {24'd0, cyc});
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Asynchronous reset asserted between edges; released 1 unit after an edge.
   task automatic do_reset();
      reset_n = 1'b0;
      #2;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n     = 1'b1;
      light       = R;
      clear_fault = 1'b0;
      #1;

      // 1. Reset values, then entry into RUN on the first RED edge.
      do_reset();
      chk_a("t1_reset", 1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
      step();
      chk_a("t1_first_red", 1'b1, 1'b0, 3'd0, 8'd1, 8'd0);

      // 2. One edge per colour: G,Y,R,G,Y,R after the entering R.
      light = G; step(); chk_a("t2_g1", 1'b1, 1'b0, 3'd0, 8'd1, 8'd0);
      light = Y; step(); chk_a("t2_y1", 1'b1, 1'b0, 3'd0, 8'd1, 8'd0);
      light = R; step(); chk_a("t2_r1", 1'b1, 1'b0, 3'd0, 8'd1, 8'd1);
      light = G; step(); chk_a("t2_g2", 1'b1, 1'b0, 3'd0, 8'd1, 8'd1);
      light = Y; step(); chk_a("t2_y2", 1'b1, 1'b0, 3'd0, 8'd1, 8'd1);
      light = R; step(); chk_a("t2_r2", 1'b1, 1'b0, 3'd0, 8'd1, 8'd2);

      // clear_fault while running has no effect.
      clear_fault = 1'b1; light = R; step(); clear_fault = 1'b0;
      chk_a("t2_clr_in_run", 1'b1, 1'b0, 3'd0, 8'd2, 8'd2);

      // 3. R then Y (G skipped): sequence error, then outputs frozen.
      light = R; do_reset();
      step();
      light = Y; step(); chk_a("t3_skip", 1'b0, 1'b1, 3'd2, 8'd1, 8'd0);
      for (int i = 0; i < 4; i++) begin
         light = 3'($urandom_range(0, 7));
         step();
         chk_a("t3_hold", 1'b0, 1'b1, 3'd2, 8'd1, 8'd0);
      end

      // 4. Illegal pattern in RUN, clear, restart; cycle_count retained.
      light = R; do_reset();
      step();
      light = G; step();
      light = Y; step();
      light = R; step(); chk_a("t4_cycle", 1'b1, 1'b0, 3'd0, 8'd1, 8'd1);
      light = G; step();
      light = 3'b110; step(); chk_a("t4_illegal", 1'b0, 1'b1, 3'd1, 8'd1, 8'd1);
      light = G; clear_fault = 1'b1; step(); clear_fault = 1'b0;
      chk_a("t4_cleared", 1'b0, 1'b0, 3'd0, 8'd0, 8'd1);
      light = 3'b111; step(); chk_a("t4_idle_ignores", 1'b0, 1'b0, 3'd0, 8'd0, 8'd1);
      light = R; step(); chk_a("t4_rerun", 1'b1, 1'b0, 3'd0, 8'd1, 8'd1);

      // 5. RED held 17 edges: 16 are fine, the 17th faults with dwell 16.
      light = R; do_reset();
      for (int i = 1; i <= 16; i++) begin
         step();
         chk({"t5_dwell"}, {24'd0, dwell_a}, i);
         chk({"t5_nofault"}, {31'd0, fault_a}, 32'd0);
      end
      step(); chk_a("t5_long", 1'b0, 1'b1, 3'd4, 8'd16, 8'd0);

      // 6a. MIN_DWELL=3 instance: R x3, G x2, then Y is too short.
      light = R; do_reset();
      step(); step(); step();
      chk({"t6_b_dwell_r"}, {24'd0, dwell_b}, 32'd3);
      light = G; step(); step();
      chk({"t6_b_dwell_g"}, {24'd0, dwell_b}, 32'd2);
      chk({"t6_b_nofault"}, {31'd0, fault_b}, 32'd0);
      light = Y; step();
      chk({"t6_b_fault"}, {31'd0, fault_b}, 32'd1);
      chk({"t6_b_code"}, {29'd0, code_b}, 32'd3);
      chk({"t6_b_dwell_frz"}, {24'd0, dwell_b}, 32'd2);
      chk({"t6_b_running"}, {31'd0, running_b}, 32'd0);

      // 6b. Reset asserted mid-RUN clears outputs with no clock edge.
      light = R; do_reset();
      step();
      light = G; step();
      light = Y; step();
      light = R; step();
      chk_a("t6_pre_rst", 1'b1, 1'b0, 3'd0, 8'd1, 8'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk_a("t6_async_rst", 1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
      reset_n = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lamp_sequence_monitor.md
Name: lamp_sequence_monitor

Overview:
- Downstream checker for the cyclic traffic-lamp controller. It consumes the controller's 3-bit one-hot `light` output every clock.
- It checks that every value is a legal one-hot colour, that colours follow the order RED→GREEN→YELLOW→RED, and that each colour's dwell stays within configured bounds.
- Any violation latches a sticky fault with a cause code.
- It also counts completed lamp cycles, for supervision logic and bench scoreboarding.

Parameters:
- CNT_W, 8, width of the `dwell` and `cycle_count` counters.
- MIN_DWELL, 1, minimum number of sampling edges a colour must be held before it changes (1..2^CNT_W-1).
- MAX_DWELL, 16, maximum number of sampling edges a colour may be held (MIN_DWELL..2^CNT_W-2).

Ports:
- clock, input, 1, rising-edge clock; same clock as the lamp controller.
- reset_n, input, 1, asynchronous active-low reset.
- light, input, 3, lamp colour: 3'b100=RED, 3'b010=GREEN, 3'b001=YELLOW.
- clear_fault, input, 1, synchronous request to leave FAULT.
- running, output, 1, high while in the RUN state.
- fault, output, 1, sticky fault flag.
- fault_code, output, 3, cause: 0=none, 1=illegal pattern, 2=sequence error, 3=dwell too short, 4=dwell too long.
- dwell, output, CNT_W, number of sampling edges the current colour has been held.
- cycle_count, output, CNT_W, count of completed YELLOW→RED transitions; saturates.

Behaviour:
- Registers and timing:
  - All state is registered on posedge clock; there are no combinational paths from inputs to outputs.
  - `light` is sampled every edge into light_q.
  - Response latency: a violation present on `light` before edge N shows on `fault`/`fault_code` immediately after edge N.
- Reset (reset_n low, asynchronous):
  - State goes to IDLE; light_q=3'b000.
  - running=0, fault=0, fault_code=0, dwell=0, cycle_count=0.
  - Reset asserted mid-RUN or mid-FAULT clears everything immediately, without waiting for a clock edge.
- State IDLE:
  - Waits for the first RED sample; every other value, including illegal ones, is ignored with no fault.
  - On a RED sample: go to RUN, dwell←1.
- State RUN: checks are applied at each edge in the priority order below; the first match wins.
  1. light not one-hot (000, 011, 101, 110, 111) → FAULT, code 1.
  2. light ≠ light_q and light is not the successor of light_q → FAULT, code 2. Successors: RED→GREEN, GREEN→YELLOW, YELLOW→RED.
  3. Legal change with dwell < MIN_DWELL → FAULT, code 3.
  4. light = light_q and dwell = MAX_DWELL → FAULT, code 4. The colour is still present on the (MAX_DWELL+1)-th sampling edge.
  5. Otherwise:
     - Unchanged colour: dwell←dwell+1.
     - Legal change: dwell←1. If the change is YELLOW→RED, cycle_count←cycle_count+1, saturating at 2^CNT_W-1 (no wrap).
- State FAULT:
  - fault=1 and running=0. fault_code, dwell and cycle_count hold their values at the moment of the fault.
  - Later `light` values are not checked.
  - On clear_fault=1: go to IDLE, fault←0, fault_code←0, dwell←0. cycle_count is retained.
  - clear_fault in IDLE or RUN is ignored.
- Entering FAULT sets fault and fault_code in the same edge; dwell is not updated on the faulting edge.
- running=1 exactly when the state is RUN.
- The lamp controller's one-cycle-per-colour pattern (R,G,Y,R,…) with default parameters must never fault.

Test Plan:
1. Pulse reset_n low with light=3'b100 → all outputs 0, running=0. First posedge after release → running=1, dwell=1.
2. Defaults; drive R,G,Y,R,G,Y,R, one per clock → fault=0 throughout, dwell=1 at every edge, cycle_count=2 after the final R.
3. RUN on R, then drive Y (skipping G) → after that edge fault=1, fault_code=2, running=0. Hold several clocks with random light → outputs unchanged.
4. RUN on G, then drive 3'b110 → fault=1, fault_code=1. Assert clear_fault for one clock with light=3'b010 → IDLE, fault=0, code=0, cycle_count retained. Next R → running=1.
5. MAX_DWELL=16; hold RED for 17 sampling edges → edges 1–16 give no fault with dwell reaching 16. Edge 17 gives fault_code=4 with dwell=16.
6. MIN_DWELL=3; R held 3 edges, then G held 2 edges, then Y → fault_code=3 at the Y edge. Separately, assert reset_n low mid-RUN between edges → outputs clear immediately, with no clock edge.
